// File: rtl/uart_tx_line_arbiter.sv
// uart_tx_line_arbiter
//   Shares one UART TX byte channel between N_REQ requesters. A grant is held
//   for a whole console line: it is released when the owner's accepted byte is
//   8'h0A, when MAX_LINE bytes have been accepted, or when the owner has had no
//   valid byte for IDLE_TIMEOUT consecutive cycles (0 disables the timeout).
//   New grants are issued round-robin, starting after the last owner.
//
//   Optional feature macro: UART_LINE_TAG_EN
//     When defined, each grant starts with a two-byte tag ('0'+owner, ':')
//     emitted by the arbiter before the owner's bytes are passed through.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_valid_i   per-requester byte valid
//   req_data_i    per-requester byte, requester k on [8k+7:8k]
//   req_ready_o   per-requester accept (only the owner, only while streaming)
//   tx_valid_o    byte valid to the serializer
//   tx_data_o     byte to the serializer
//   tx_ready_i    serializer accept
//   grant_o       one-hot owner, zero when idle
//   busy_o        a grant is active
//   timeout_o     one-cycle pulse on the cycle a timeout release happens
module uart_tx_line_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned MAX_LINE     = 255,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int unsigned GW = $clog2(N_REQ);
  localparam int unsigned SW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [8:0]  LINE_LIM  = 9'(MAX_LINE);
  localparam logic [SW:0] STALL_LIM = (SW + 1)'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
`ifdef UART_LINE_TAG_EN
    ST_PFX_ID,
    ST_PFX_SEP,
`endif
    ST_STREAM
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   owner_q, owner_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [7:0]      byte_cnt_q, byte_cnt_d;
  logic [SW-1:0]   stall_cnt_q, stall_cnt_d;

  logic            owner_valid;
  logic [7:0]      owner_data;
  logic            pick_found;
  logic [GW-1:0]   pick_idx;
  logic            accept;
  logic            release_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      byte_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Owner's request lane.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (owner_q == GW'(k)) begin
        owner_valid = req_valid_i[k];
        owner_data  = req_data_i[8*k +: 8];
      end
    end
  end

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_found && req_valid_i[GW'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(idx);
      end
    end
  end

  always_comb begin
    busy_o = (state_q != ST_IDLE);
    for (int unsigned k = 0; k < N_REQ; k++) begin
      grant_o[k] = busy_o && (owner_q == GW'(k));
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    byte_cnt_d  = byte_cnt_q;
    stall_cnt_d = stall_cnt_q;
    req_ready_o = '0;
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    timeout_o   = 1'b0;
    accept      = 1'b0;
    release_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          owner_d     = pick_idx;
          byte_cnt_d  = '0;
          stall_cnt_d = '0;
`ifdef UART_LINE_TAG_EN
          state_d     = ST_PFX_ID;
`else
          state_d     = ST_STREAM;
`endif
        end
      end
`ifdef UART_LINE_TAG_EN
      ST_PFX_ID: begin
        tx_valid_o = 1'b1;
        tx_data_o  = 8'h30 + 8'(owner_q);
        if (tx_ready_i) state_d = ST_PFX_SEP;
      end
      ST_PFX_SEP: begin
        tx_valid_o = 1'b1;
        tx_data_o  = 8'h3A;
        if (tx_ready_i) state_d = ST_STREAM;
      end
`endif
      ST_STREAM: begin
        tx_valid_o = owner_valid;
        tx_data_o  = owner_data;
        for (int unsigned k = 0; k < N_REQ; k++) begin
          req_ready_o[k] = (owner_q == GW'(k)) && tx_ready_i;
        end
        accept = owner_valid && tx_ready_i;
        if (accept) begin
          byte_cnt_d  = byte_cnt_q + 8'd1;
          stall_cnt_d = '0;
          // LF and line-length limit may coincide; either yields one release.
          if (owner_data == 8'h0A || ({1'b0, byte_cnt_q} + 9'd1) == LINE_LIM) begin
            release_c = 1'b1;
          end
        end else if (owner_valid) begin
          // Back-pressure from the serializer is not a stall.
          stall_cnt_d = '0;
        end else if (IDLE_TIMEOUT != 0) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
          if (({1'b0, stall_cnt_q} + 1'b1) == STALL_LIM) begin
            release_c = 1'b1;
            timeout_o = 1'b1;
          end
        end
        if (release_c) begin
          state_d     = ST_IDLE;
          ptr_d       = (owner_q == GW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
          byte_cnt_d  = '0;
          stall_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_line_arbiter.sv
// Bench for uart_tx_line_arbiter (N_REQ=4, MAX_LINE=4, IDLE_TIMEOUT=8).
// Requesters are modelled as byte queues; every byte expected on the TX side
// is pushed to a scoreboard in the order the round-robin line policy implies.
module tb_uart_tx_line_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]   req_ready_o;
  logic           tx_valid_o;
  logic [7:0]     tx_data_o;
  logic           tx_ready_i;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic           timeout_o;

  uart_tx_line_arbiter #(
    .N_REQ(N),
    .MAX_LINE(4),
    .IDLE_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid_i(req_valid_i),
    .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .tx_valid_o(tx_valid_o),
    .tx_data_o(tx_data_o),
    .tx_ready_i(tx_ready_i),
    .grant_o(grant_o),
    .busy_o(busy_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] src;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] src_q[N][$];
  int         total = 0;
  int         bad = 0;
  logic       gap;
  exp_t       e;

  logic         obs_txv, obs_txhs, obs_busy, obs_to;
  logic [7:0]   obs_data;
  logic [N-1:0] obs_grant, obs_rdy;

  task automatic drive_reqs();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0) begin
        req_valid_i[k] = 1'b1;
        req_data_i[k*8 +: 8] = src_q[k][0];
      end else begin
        req_valid_i[k] = 1'b0;
        req_data_i[k*8 +: 8] = 8'h00;
      end
    end
  endtask

  // Sample at negedge, then advance past posedge and retire accepted bytes.
  task automatic cycle();
    logic [N-1:0] hs;
    @(negedge clk);
    obs_txv   = tx_valid_o;
    obs_txhs  = tx_valid_o & tx_ready_i;
    obs_data  = tx_data_o;
    obs_grant = grant_o;
    obs_busy  = busy_o;
    obs_to    = timeout_o;
    obs_rdy   = req_ready_o;
    hs = req_valid_i & req_ready_o;
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      end
    end
    drive_reqs();
  endtask

  task automatic load(input int src, input string s);
    for (int i = 0; i < s.len(); i++) src_q[src].push_back(s[i]);
    drive_reqs();
  endtask

  task automatic expect_line(input int src, input string s, input bit rel);
    exp_t x;
    x.src = 4'(src);
`ifdef UART_LINE_TAG_EN
    x.last = 1'b0;
    x.data = 8'h30 + 8'(src);
    exp_q.push_back(x);
    x.data = 8'h3A;
    exp_q.push_back(x);
`endif
    for (int i = 0; i < s.len(); i++) begin
      x.data = s[i];
      x.last = rel && (i == s.len() - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_ready_i = 1'b1;
    for (int k = 0; k < N; k++) begin
      load(k, "\n");
      expect_line(k, "\n", 1'b1);
    end
    for (int c = 0; c < 3; c++) begin
      cycle();
      total++;
      if ({obs_rdy, obs_txv, obs_data, obs_grant, obs_busy, obs_to} !== '0) begin
        bad++;
        $display("FAIL reset_outputs rdy=%b txv=%b data=%h grant=%b busy=%b to=%b required all 0",
                 obs_rdy, obs_txv, obs_data, obs_grant, obs_busy, obs_to);
      end
    end
    rst = 1'b0;
    gap = 1'b0;
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      cycle();
      if (gap) begin
        total++; gap = 1'b0;
        if (obs_busy !== 1'b0) begin bad++; $display("FAIL reset_gap busy=%b required 0", obs_busy); end
      end
      if (obs_txhs) begin
        e = exp_q.pop_front(); total++;
        if (obs_data !== e.data || obs_grant !== (4'b0001 << e.src)) begin
          bad++;
          $display("FAIL reset_byte data=%h grant=%b required data=%h grant=%b", obs_data, obs_grant, e.data, 4'b0001 << e.src);
        end
        gap = e.last;
      end
    end
    if (exp_q.size() != 0) begin total++; bad++; $display("FAIL reset_drain left=%0d required 0", exp_q.size()); exp_q.delete(); end
    if (gap) begin
      cycle(); total++;
      if (obs_busy !== 1'b0) begin bad++; $display("FAIL reset_gap busy=%b required 0", obs_busy); end
    end
  endtask

  task automatic test_line_handoff();
    load(1, "hi\n");
    load(2, "zz\n");
    expect_line(1, "hi\n", 1'b1);
    expect_line(2, "zz\n", 1'b1);
    gap = 1'b0;
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      cycle();
      if (gap) begin
        total++; gap = 1'b0;
        if (obs_busy !== 1'b0) begin bad++; $display("FAIL handoff_gap busy=%b required 0", obs_busy); end
      end
      if (obs_txhs) begin
        e = exp_q.pop_front(); total++;
        if (obs_data !== e.data || obs_grant !== (4'b0001 << e.src)) begin
          bad++;
          $display("FAIL handoff_byte data=%h grant=%b required data=%h grant=%b", obs_data, obs_grant, e.data, 4'b0001 << e.src);
        end
        gap = e.last;
      end
    end
    if (exp_q.size() != 0) begin total++; bad++; $display("FAIL handoff_drain left=%0d required 0", exp_q.size()); exp_q.delete(); end
    if (gap) begin
      cycle(); total++;
      if (obs_busy !== 1'b0) begin bad++; $display("FAIL handoff_gap busy=%b required 0", obs_busy); end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < N; k++) load(k, "x\nx\n");
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) expect_line(k, "x\n", 1'b1);
    gap = 1'b0;
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      cycle();
      if (gap) begin
        total++; gap = 1'b0;
        if (obs_busy !== 1'b0) begin bad++; $display("FAIL rr_gap busy=%b required 0", obs_busy); end
      end
      if (obs_txhs) begin
        e = exp_q.pop_front(); total++;
        if (obs_data !== e.data || obs_grant !== (4'b0001 << e.src)) begin
          bad++;
          $display("FAIL rr_byte data=%h grant=%b required data=%h grant=%b", obs_data, obs_grant, e.data, 4'b0001 << e.src);
        end
        gap = e.last;
      end
    end
    if (exp_q.size() != 0) begin total++; bad++; $display("FAIL rr_drain left=%0d required 0", exp_q.size()); exp_q.delete(); end
    if (gap) cycle();
  endtask

  task automatic test_max_line();
    bit seen;
    do_reset();
    load(0, "ABCDEF");
    load(1, "q\n");
    expect_line(0, "ABCD", 1'b1);
    expect_line(1, "q\n", 1'b1);
    expect_line(0, "EF", 1'b0);
    gap = 1'b0;
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      cycle();
      if (gap) begin
        total++; gap = 1'b0;
        if (obs_busy !== 1'b0) begin bad++; $display("FAIL maxline_gap busy=%b required 0", obs_busy); end
      end
      if (obs_txhs) begin
        e = exp_q.pop_front(); total++;
        if (obs_data !== e.data || obs_grant !== (4'b0001 << e.src)) begin
          bad++;
          $display("FAIL maxline_byte data=%h grant=%b required data=%h grant=%b", obs_data, obs_grant, e.data, 4'b0001 << e.src);
        end
        gap = e.last;
      end
    end
    if (exp_q.size() != 0) begin total++; bad++; $display("FAIL maxline_drain left=%0d required 0", exp_q.size()); exp_q.delete(); end
    // req0 has nothing after F, so its second grant ends by timeout.
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      cycle();
      if (obs_to) seen = 1'b1;
    end
    total++;
    if (!seen || obs_grant !== 4'b0001) begin
      bad++;
      $display("FAIL maxline_tail_timeout seen=%b grant=%b required seen=1 grant=0001", seen, obs_grant);
    end
    cycle();
  endtask

  task automatic test_idle_timeout();
    int since;
    int to_at;
    int viol;
    load(3, "Z");
    expect_line(3, "Z", 1'b0);
    since = -1;
    to_at = -1;
    for (int c = 0; c < 60 && to_at < 0; c++) begin
      cycle();
      if (since >= 0) since++;
      if (obs_txhs) begin
        e = exp_q.pop_front(); total++;
        if (obs_data !== e.data || obs_grant !== (4'b0001 << e.src)) begin
          bad++;
          $display("FAIL timeout_byte data=%h grant=%b required data=%h grant=%b", obs_data, obs_grant, e.data, 4'b0001 << e.src);
        end
        if (exp_q.size() == 0) since = 0;
      end
      if (obs_to) to_at = since;
    end
    total++;
    if (to_at != 8) begin bad++; $display("FAIL timeout_delay cycles=%0d required 8", to_at); end
    exp_q.delete();
    cycle();
    total++;
    if (obs_busy !== 1'b0 || obs_grant !== 4'b0000) begin
      bad++;
      $display("FAIL timeout_release busy=%b grant=%b required busy=0 grant=0000", obs_busy, obs_grant);
    end
    // Serializer back-pressure with valid held must never time out.
    tx_ready_i = 1'b0;
    load(3, "W\n");
    expect_line(3, "W\n", 1'b1);
    viol = 0;
    for (int c = 0; c < 100; c++) begin
      cycle();
      if (obs_to) viol++;
    end
    total++;
    if (viol != 0 || obs_busy !== 1'b1) begin
      bad++;
      $display("FAIL backpressure pulses=%0d busy=%b required pulses=0 busy=1", viol, obs_busy);
    end
    tx_ready_i = 1'b1;
    gap = 1'b0;
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      cycle();
      if (obs_txhs) begin
        e = exp_q.pop_front(); total++;
        if (obs_data !== e.data || obs_grant !== (4'b0001 << e.src)) begin
          bad++;
          $display("FAIL backpressure_byte data=%h grant=%b required data=%h grant=%b", obs_data, obs_grant, e.data, 4'b0001 << e.src);
        end
        gap = e.last;
      end
    end
    if (exp_q.size() != 0) begin total++; bad++; $display("FAIL backpressure_drain left=%0d required 0", exp_q.size()); exp_q.delete(); end
    cycle();
  endtask

  task automatic test_reset_midline();
    load(2, "ok\n");
`ifdef UART_LINE_TAG_EN
    expect_line(2, "", 1'b0);
`else
    expect_line(2, "o", 1'b0);
`endif
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      cycle();
      if (obs_txhs) begin
        e = exp_q.pop_front(); total++;
        if (obs_data !== e.data || obs_grant !== (4'b0001 << e.src)) begin
          bad++;
          $display("FAIL midline_byte data=%h grant=%b required data=%h grant=%b", obs_data, obs_grant, e.data, 4'b0001 << e.src);
        end
      end
    end
    if (exp_q.size() != 0) begin total++; bad++; $display("FAIL midline_drain left=%0d required 0", exp_q.size()); exp_q.delete(); end
    rst = 1'b1;
    tx_ready_i = 1'b0;
    cycle();
    cycle();
    total++;
    if ({obs_rdy, obs_txv, obs_data, obs_grant, obs_busy, obs_to} !== '0) begin
      bad++;
      $display("FAIL midline_reset rdy=%b txv=%b data=%h grant=%b busy=%b to=%b required all 0",
               obs_rdy, obs_txv, obs_data, obs_grant, obs_busy, obs_to);
    end
    src_q[2].delete();
    drive_reqs();
    rst = 1'b0;
    tx_ready_i = 1'b1;
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    tx_ready_i = 1'b1;
    req_valid_i = '0;
    req_data_i = '0;
    test_reset();
    test_line_handoff();
    test_round_robin();
    test_max_line();
    test_idle_timeout();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
